// File: rtl/event_detector_mc.sv
// event_detector_mc: multi-channel energy event detector with start/end hysteresis, debounce and a
// global saturating start counter. Define EVT_DURATION_EN to capture per-channel event durations.

module event_detector_ch #(
   parameter int WIDTH        = 64,
   parameter int START_FACTOR = 3,
   parameter int END_FACTOR   = 2,
   parameter int MIN_ON       = 4,
   parameter int MIN_OFF      = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 init_done_i,
   input  logic                 sample_valid_i,
   input  logic [WIDTH-1:0]     energy_i,
   input  logic [WIDTH-1:0]     th_i,
   output logic                 start_next_o,
   output logic                 detected_o,
   output logic                 start_o,
   output logic                 end_o,
   output logic [CNT_WIDTH-1:0] last_duration_o
);
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ARMING, S_ACTIVE, S_RELEASING} state_t;

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d, cnt_inc;
   logic [WIDTH+7:0] energy_x, start_lvl, end_lvl;
   logic             above_start, below_end;
   logic             start_d, end_d, detected_d;
   logic             start_q, end_q, detected_q;

   // 8 guard bits: factor <= 255 so the product can never wrap
   assign energy_x    = {8'd0, energy_i};
   assign start_lvl   = {8'd0, th_i} * (WIDTH+8)'(START_FACTOR);
   assign end_lvl     = {8'd0, th_i} * (WIDTH+8)'(END_FACTOR);
   assign above_start = energy_x > start_lvl;
   assign below_end   = energy_x < end_lvl;
   assign cnt_inc     = cnt_q + 8'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: if (init_done_i) state_d = S_IDLE;
         S_IDLE: if (sample_valid_i && above_start) begin
            if (MIN_ON == 1) state_d = S_ACTIVE;
            else begin
               state_d = S_ARMING;
               cnt_d   = 8'd1;
            end
         end
         S_ARMING: if (sample_valid_i) begin
            if (!above_start) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == 8'(MIN_ON)) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else cnt_d = cnt_inc;
         end
         S_ACTIVE: if (sample_valid_i && below_end) begin
            if (MIN_OFF == 1) state_d = S_IDLE;
            else begin
               state_d = S_RELEASING;
               cnt_d   = 8'd1;
            end
         end
         S_RELEASING: if (sample_valid_i) begin
            if (!below_end) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else if (cnt_inc == 8'(MIN_OFF)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else cnt_d = cnt_inc;
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // RELEASING->ACTIVE is a continuation of the same event, not a new start
   always_comb begin
      start_d    = (state_q == S_IDLE || state_q == S_ARMING) && state_d == S_ACTIVE;
      end_d      = (state_q == S_ACTIVE || state_q == S_RELEASING) && state_d == S_IDLE;
      detected_d = (state_d == S_ACTIVE || state_d == S_RELEASING);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         start_q    <= 1'b0;
         end_q      <= 1'b0;
         detected_q <= 1'b0;
      end else begin
         start_q    <= start_d;
         end_q      <= end_d;
         detected_q <= detected_d;
      end
   end

   assign start_next_o = start_d;
   assign start_o      = start_q;
   assign end_o        = end_q;
   assign detected_o   = detected_q;

`ifdef EVT_DURATION_EN
   logic [CNT_WIDTH-1:0] dur_q, dur_d, dur_inc, last_q, last_d;

   assign dur_inc = (dur_q == '1) ? dur_q : dur_q + CNT_WIDTH'(1);

   // the arming samples belong to the event, so counting starts at MIN_ON
   always_comb begin
      dur_d  = dur_q;
      last_d = last_q;
      if (start_d) dur_d = CNT_WIDTH'(MIN_ON);
      else if (sample_valid_i && detected_q) dur_d = dur_inc;
      if (end_d) last_d = dur_inc;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dur_q  <= '0;
         last_q <= '0;
      end else begin
         dur_q  <= dur_d;
         last_q <= last_d;
      end
   end

   assign last_duration_o = last_q;
`else
   assign last_duration_o = '0;
`endif
endmodule

module event_detector_mc #(
   parameter int NUM_CH       = 4,
   parameter int WIDTH        = 64,
   parameter int START_FACTOR = 3,
   parameter int END_FACTOR   = 2,
   parameter int MIN_ON       = 4,
   parameter int MIN_OFF      = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          init_done,
   input  logic                          sample_valid,
   input  logic [NUM_CH*WIDTH-1:0]       energy,
   input  logic [NUM_CH*WIDTH-1:0]       th,
   input  logic                          clear_count,
   output logic [NUM_CH-1:0]             event_detected,
   output logic [NUM_CH-1:0]             event_start,
   output logic [NUM_CH-1:0]             event_end,
   output logic                          any_event,
   output logic [CNT_WIDTH-1:0]          event_count,
   output logic [NUM_CH*CNT_WIDTH-1:0]   last_duration
);
   logic [NUM_CH-1:0]    start_next;
   logic [CNT_WIDTH:0]   pop, sum;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      event_detector_ch #(
         .WIDTH(WIDTH), .START_FACTOR(START_FACTOR), .END_FACTOR(END_FACTOR),
         .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .CNT_WIDTH(CNT_WIDTH)
      ) u_ch (
         .clock           (clock),
         .reset           (reset),
         .init_done_i     (init_done),
         .sample_valid_i  (sample_valid),
         .energy_i        (energy[i*WIDTH +: WIDTH]),
         .th_i            (th[i*WIDTH +: WIDTH]),
         .start_next_o    (start_next[i]),
         .detected_o      (event_detected[i]),
         .start_o         (event_start[i]),
         .end_o           (event_end[i]),
         .last_duration_o (last_duration[i*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   // count moves on the same edge the start pulses rise; a clear keeps this cycle's starts
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) pop = pop + (CNT_WIDTH+1)'(start_next[i]);
      sum = {1'b0, count_q} + pop;
      if (clear_count)        count_d = pop[CNT_WIDTH-1:0];
      else if (sum[CNT_WIDTH]) count_d = '1;
      else                    count_d = sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign event_count = count_q;
   assign any_event   = |event_detected;
endmodule

// File: tb/tb_event_detector_mc.sv
// Bench for event_detector_mc: directed scenarios plus randomized traffic against a run-length model.
`timescale 1ns/1ps
module tb_event_detector_mc;
   localparam int NUM_CH = 4, WIDTH = 64, SF = 3, EF = 2, MIN_ON = 4, MIN_OFF = 4, CW = 6;
   localparam int MAXC = (1 << CW) - 1;
   localparam int VW = 3*NUM_CH + 1 + CW + NUM_CH*CW;

   logic clock = 0, reset = 1, init_done = 0, sample_valid = 0, clear_count = 0;
   logic [NUM_CH*WIDTH-1:0] energy = '0, th = '0;
   logic [NUM_CH-1:0] event_detected, event_start, event_end;
   logic any_event;
   logic [CW-1:0] event_count;
   logic [NUM_CH*CW-1:0] last_duration;
   logic [VW-1:0] dut_vec;
   int tests = 0, fails = 0;

   // reference model: in-event flag, run length of qualifying samples, durations
   bit m_ready;
   bit m_in [NUM_CH];
   int m_run [NUM_CH], m_dur [NUM_CH], m_last [NUM_CH];
   int m_cnt;
   logic [NUM_CH-1:0] m_start, m_end;

   always #5 clock = ~clock;

   event_detector_mc #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .START_FACTOR(SF), .END_FACTOR(EF),
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset), .init_done(init_done), .sample_valid(sample_valid),
      .energy(energy), .th(th), .clear_count(clear_count),
      .event_detected(event_detected), .event_start(event_start), .event_end(event_end),
      .any_event(any_event), .event_count(event_count), .last_duration(last_duration)
   );

   assign dut_vec = {event_detected, event_start, event_end, any_event, event_count, last_duration};

   function automatic logic [VW-1:0] exp_vec();
      logic [NUM_CH-1:0] det;
      logic [NUM_CH*CW-1:0] last;
      det = '0;
      last = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         det[c] = m_in[c];
`ifdef EVT_DURATION_EN
         last[c*CW +: CW] = CW'(m_last[c]);
`endif
      end
      return {det, m_start, m_end, |det, CW'(m_cnt), last};
   endfunction

   task automatic model_step();
      int pop;
      logic [WIDTH+7:0] e, t;
      m_start = '0;
      m_end = '0;
      pop = 0;
      if (reset) begin
         m_ready = 0;
         m_cnt = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_in[c] = 0; m_run[c] = 0; m_dur[c] = 0; m_last[c] = 0;
         end
         return;
      end
      if (!m_ready) m_ready = init_done;
      else if (sample_valid) begin
         for (int c = 0; c < NUM_CH; c++) begin
            e = {8'd0, energy[c*WIDTH +: WIDTH]};
            t = {8'd0, th[c*WIDTH +: WIDTH]};
            if (!m_in[c]) begin
               if (e > t * SF) begin
                  m_run[c]++;
                  if (m_run[c] == MIN_ON) begin
                     m_in[c] = 1; m_run[c] = 0; m_start[c] = 1; m_dur[c] = MIN_ON; pop++;
                  end
               end else m_run[c] = 0;
            end else begin
               m_dur[c] = (m_dur[c] < MAXC) ? m_dur[c] + 1 : MAXC;
               if (e < t * EF) begin
                  m_run[c]++;
                  if (m_run[c] == MIN_OFF) begin
                     m_in[c] = 0; m_run[c] = 0; m_end[c] = 1; m_last[c] = m_dur[c];
                  end
               end else m_run[c] = 0;
            end
         end
      end
      if (clear_count) m_cnt = pop;
      else m_cnt = (m_cnt + pop > MAXC) ? MAXC : m_cnt + pop;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic set_ch(int c, logic [WIDTH-1:0] e, logic [WIDTH-1:0] t);
      energy[c*WIDTH +: WIDTH] = e;
      th[c*WIDTH +: WIDTH] = t;
   endtask

   task automatic drive_mask(logic [NUM_CH-1:0] m, logic [WIDTH-1:0] e);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, m[c] ? e : '0, 64'd100);
   endtask

   task automatic test_reset();
      reset = 1; sample_valid = 1; init_done = 1; drive_mask('1, 64'd301);
      tick(); tick();
      tests++;
      if (dut_vec !== '0) begin fails++; $display("FAIL reset_zero: got %h want 0", dut_vec); end
      reset = 0; init_done = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec() || event_detected !== '0) begin
            fails++; $display("FAIL init_hold: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_basic();
      sample_valid = 0; init_done = 1; tick(); init_done = 0;
      drive_mask(4'b0001, 64'd301); sample_valid = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin
            fails++; $display("FAIL basic_model: got %h want %h", dut_vec, exp_vec());
         end
      end
      tests++;
      if ({event_start, event_detected, any_event, event_count} !== {4'b0001, 4'b0001, 1'b1, CW'(1)}) begin
         fails++; $display("FAIL basic_start: got st=%b det=%b any=%b cnt=%0d want 0001 0001 1 1",
                           event_start, event_detected, any_event, event_count);
      end
   endtask

   task automatic test_equal();
      drive_mask('0, '0);
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL equal_end: got %h want %h", dut_vec, exp_vec()); end
      end
      tests++;
      if (event_end !== 4'b0001) begin fails++; $display("FAIL equal_endpulse: got %b want 0001", event_end); end
      drive_mask('1, 64'd300);
      for (int i = 0; i < 20; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec() || event_detected !== '0 || event_start !== '0) begin
            fails++; $display("FAIL equal_thresh: got %h want %h", dut_vec, exp_vec());
         end
      end
      for (int c = 0; c < NUM_CH; c++) set_ch(c, '1, '1);
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec() || event_detected !== '0) begin
            fails++; $display("FAIL wide_thresh: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 12; i++) begin
         if (i == 3) drive_mask(4'b0010, 64'd250);
         else if (i < 8) drive_mask(4'b0010, 64'd301);
         else drive_mask(4'b0010, 64'd199);
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL abort_model[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
         if (i == 3) begin
            tests++;
            if (event_detected !== '0) begin fails++; $display("FAIL abort_idle: got %b want 0", event_detected); end
         end
         if (i == 7) begin
            tests++;
            if (event_start !== 4'b0010) begin fails++; $display("FAIL abort_start: got %b want 0010", event_start); end
         end
      end
      tests++;
      if (event_end !== 4'b0010) begin fails++; $display("FAIL abort_end: got %b want 0010", event_end); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 18; i++) begin
         sample_valid = !(i >= 6 && i < 16);
         if (i < 4) drive_mask(4'b0100, 64'd301);
         else if (i >= 6 && i < 16) drive_mask(4'b0100, 64'd0);
         else drive_mask(4'b0100, 64'd199);
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL hold_model[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
         if (i >= 6 && i < 17) begin
            tests++;
            if (event_detected !== 4'b0100 || event_end !== '0) begin
               fails++; $display("FAIL hold_state[%0d]: got det=%b end=%b want 0100 0000", i, event_detected, event_end);
            end
         end
      end
      tests++;
      if (event_end !== 4'b0100) begin fails++; $display("FAIL hold_end: got %b want 0100", event_end); end
   endtask

   task automatic test_clear();
      sample_valid = 0; clear_count = 1; tick(); clear_count = 0; sample_valid = 1;
      tests++;
      if (event_count !== '0) begin fails++; $display("FAIL clear_zero: got %0d want 0", event_count); end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) begin
            drive_mask(r == 0 ? 4'b1111 : 4'b0111, i < 4 ? 64'd301 : 64'd0);
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL clear_setup: got %h want %h", dut_vec, exp_vec()); end
         end
      end
      tests++;
      if (event_count !== CW'(7)) begin fails++; $display("FAIL clear_seven: got %0d want 7", event_count); end
      for (int i = 0; i < 8; i++) begin
         drive_mask(4'b0101, i < 4 ? 64'd301 : 64'd0);
         clear_count = (i == 3);
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL clear_model: got %h want %h", dut_vec, exp_vec()); end
         if (i == 3) begin
            tests++;
            if (event_count !== CW'(2) || event_start !== 4'b0101) begin
               fails++; $display("FAIL clear_same_cycle: got cnt=%0d st=%b want 2 0101", event_count, event_start);
            end
         end
      end
      clear_count = 0;
      for (int r = 0; r < 17; r++) begin
         for (int i = 0; i < 8; i++) begin
            drive_mask('1, i < 4 ? 64'd301 : 64'd0);
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL sat_model: got %h want %h", dut_vec, exp_vec()); end
         end
         if (r >= 15) begin
            tests++;
            if (event_count !== CW'(MAXC)) begin fails++; $display("FAIL sat_hold: got %0d want %0d", event_count, MAXC); end
         end
      end
   endtask

   task automatic test_reset_mid();
      drive_mask(4'b0010, 64'd301);
      for (int i = 0; i < 4; i++) tick();
      reset = 1; tick(); reset = 0;
      tests++;
      if (dut_vec !== '0) begin fails++; $display("FAIL reset_mid: got %h want 0", dut_vec); end
      sample_valid = 0; init_done = 1; tick(); init_done = 0; sample_valid = 1;
      drive_mask('0, '0);
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (dut_vec !== exp_vec() || event_end !== '0) begin
            fails++; $display("FAIL reset_noend: got %h want %h", dut_vec, exp_vec());
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive_mask(4'b1000, i < 4 ? 64'd301 : (i < 6 ? 64'd250 : 64'd199));
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL dur_model: got %h want %h", dut_vec, exp_vec()); end
      end
      tests++;
`ifdef EVT_DURATION_EN
      if (last_duration[3*CW +: CW] !== CW'(10) || event_end !== 4'b1000) begin
         fails++; $display("FAIL dur_ten: got %0d end=%b want 10 1000", last_duration[3*CW +: CW], event_end);
      end
`else
      if (last_duration !== '0 || event_end !== 4'b1000) begin
         fails++; $display("FAIL dur_off: got %h end=%b want 0 1000", last_duration, event_end);
      end
`endif
   endtask

   task automatic test_random();
      int cls [NUM_CH];
      logic [WIDTH-1:0] tv, ev;
      for (int c = 0; c < NUM_CH; c++) cls[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         init_done = ($urandom_range(0, 9) == 0);
         sample_valid = ($urandom_range(0, 3) != 0);
         clear_count = ($urandom_range(0, 19) == 0);
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 3) == 0) cls[c] = $urandom_range(0, 5);
            tv = ($urandom_range(0, 20) == 0) ? '0 : 64'($urandom_range(1, 1000));
            case (cls[c])
               0, 1:    ev = tv * 3 + 1 + 64'($urandom_range(0, 50));
               2:       ev = tv * 3;
               3:       ev = tv * 2;
               4:       ev = tv * 2 - 1;
               default: ev = 64'($urandom_range(0, 4000));
            endcase
            set_ch(c, ev, tv);
         end
         tick();
         tests++;
         if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random[%0d]: got %h want %h", n, dut_vec, exp_vec()); end
      end
      reset = 0; clear_count = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal();
      test_abort();
      test_hold();
      test_clear();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
